dmem_bus_arbiter: RTL



---
 rtl/dmem_bus_arbiter_if.sv | 17 +
 rtl/dmem_bus_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dmem_bus_arbiter_if.sv
// External memory bus seen by the arbiter (master) and the memory side (slave).
// ready_n is active-low transfer-complete; busy blocks a new request.
interface dmem_bus_arbiter_if;
  logic        req;
  logic        write;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        ready_n;

  modport master (output req, write, size, addr, wdata,
                  input  rdata, busy, ready_n);
  modport slave  (input  req, write, size, addr, wdata,
                  output rdata, busy, ready_n);
endinterface

// File: rtl/dmem_bus_arbiter.sv
// Arbiter sharing one external memory bus between the fetch port (I) and the
// MEM-stage load/store port (D).
//
// Optional feature: define ARB_ROUND_ROBIN_EN to resolve simultaneous requests
// in favour of the port not granted most recently (D_PRIORITY is then unused).
// Without it, D_PRIORITY fixes the winner of a tie.
//
// state | meaning
// IDLE  | waiting for an eligible request; latches the winner's fields
// ISSUE | m_req high until the bus accepts (m_busy low)
// WAIT  | waiting for m_ready_n low, or the timeout abort
module dmem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter bit          D_PRIORITY  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  dmem_bus_arbiter_if.master m,
  output logic        err
);

  // Counter only needs to reach TIMEOUT_CYC-1.
  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state;
  logic          owner_d;
  logic [CW-1:0] cnt;
  logic          i_elig;
  logic          d_elig;
  logic          pick_d;
  logic          timeout_hit;

`ifdef ARB_ROUND_ROBIN_EN
  logic          last_d;
`endif

  // A port whose ack is high this cycle is finishing, not requesting anew.
  assign i_elig = i_req & ~i_ack;
  assign d_elig = d_req & ~d_ack;

`ifdef ARB_ROUND_ROBIN_EN
  assign pick_d = d_elig & (~i_elig | ~last_d);
`else
  assign pick_d = d_elig & (~i_elig | D_PRIORITY);
`endif

  assign timeout_hit = (TIMEOUT_CYC != 0) && (32'(cnt) == TIMEOUT_CYC - 1);

  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;

  // Arbitration, bus handshake and completion sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      cnt     <= '0;
      m.req   <= 1'b0;
      m.write <= 1'b0;
      m.size  <= 2'b00;
      m.addr  <= '0;
      m.wdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      err     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d  <= 1'b0;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_elig || d_elig) begin
            owner_d <= pick_d;
            m.req   <= 1'b1;
            state   <= ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
            last_d  <= pick_d;
`endif
            if (pick_d) begin
              m.addr  <= d_addr;
              m.size  <= d_size;
              m.write <= d_write;
              m.wdata <= d_wdata;
            end else begin
              m.addr  <= i_addr;
              m.size  <= 2'b10;
              m.write <= 1'b0;
              m.wdata <= '0;
            end
          end
        end
        ISSUE: begin
          if (!m.busy) begin
            m.req <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!m.ready_n) begin
            state <= IDLE;
            cnt   <= '0;
            if (owner_d) begin
              d_ack <= 1'b1;
              if (!m.write) d_rdata <= m.rdata;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= m.rdata;
            end
          end else if (timeout_hit) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b1;
            if (owner_d) begin
              d_ack   <= 1'b1;
              d_rdata <= '0;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
